gate_resp_misr: RTL and testbench

- Downstream response compactor for the gate-level Verilator bench.
- Consumes the INV and NAND2 output vectors every cycle and folds them into a multiple-input signature register (MISR).
- After a programmed number of valid samples, it raises done and compares the signature against an expected value. The C-TB then checks one word instead of every cycle.

---
 rtl/gate_tb_pkg.sv | 10 +
 rtl/gate_resp_misr_if.sv | 29 ++
 rtl/misr_step.sv | 18 +
 rtl/gate_resp_misr.sv | 81 ++++++++
 tb/tb_gate_resp_misr.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/gate_tb_pkg.sv
// Shared types and defaults for the gate-level response compactors.
package gate_tb_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} misr_state_t;

   localparam logic [63:0] DEFAULT_POLY = 64'hD800_0000_0000_0000;
   localparam int unsigned TB_WIDTH     = 64;
   localparam int unsigned TB_CNT_W     = 16;

endpackage

// File: rtl/gate_resp_misr_if.sv
// Control, response and status bundle between the gate bench and the MISR compactor.
interface gate_resp_misr_if
   import gate_tb_pkg::*;
#(
   parameter int unsigned WIDTH = TB_WIDTH,
   parameter int unsigned CNT_W = TB_CNT_W
);
   logic             start;
   logic [CNT_W-1:0] num_cycles;
   logic             in_valid;
   logic [WIDTH-1:0] resp_inv;
   logic [WIDTH-1:0] resp_nand2;
   logic [WIDTH-1:0] exp_sig;
   logic             busy;
   logic             done;
   logic             pass;
   logic [WIDTH-1:0] signature;
   logic [CNT_W-1:0] count;

   modport master (
      output start, num_cycles, in_valid, resp_inv, resp_nand2, exp_sig,
      input  busy, done, pass, signature, count
   );

   modport slave (
      input  start, num_cycles, in_valid, resp_inv, resp_nand2, exp_sig,
      output busy, done, pass, signature, count
   );
endinterface

// File: rtl/misr_step.sv
// One combinational MISR step folding an INV and a NAND2 response vector into the signature.
module misr_step #(
   parameter int unsigned      WIDTH = 64,
   parameter logic [WIDTH-1:0] POLY  = '0
) (
   input  logic [WIDTH-1:0] sig,
   input  logic [WIDTH-1:0] resp_inv,
   input  logic [WIDTH-1:0] resp_nand2,
   output logic [WIDTH-1:0] next_sig
);
   logic [WIDTH-1:0] folded;
   logic [WIDTH-1:0] feedback;

   // NAND2 is rotated so identical INV/NAND2 vectors do not cancel each other.
   assign folded   = resp_inv ^ {resp_nand2[0], resp_nand2[WIDTH-1:1]};
   assign feedback = sig[WIDTH-1] ? POLY : '0;
   assign next_sig = {sig[WIDTH-2:0], 1'b0} ^ feedback ^ folded;
endmodule

// File: rtl/gate_resp_misr.sv
// Response compactor: absorbs a programmed number of valid samples into a MISR, then reports done/pass.
module gate_resp_misr
   import gate_tb_pkg::*;
#(
   parameter int unsigned      WIDTH = TB_WIDTH,
   parameter int unsigned      CNT_W = TB_CNT_W,
   parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEFAULT_POLY),
   parameter logic [WIDTH-1:0] SEED  = '0
) (
   input logic             clk,
   input logic             rst,
   gate_resp_misr_if.slave bus
);
   misr_state_t      state;
   logic [WIDTH-1:0] sig_q;
   logic [WIDTH-1:0] next_sig;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] len_q;
   logic             busy_q;
   logic             done_q;

   misr_step #(.WIDTH(WIDTH), .POLY(POLY)) u_step (
      .sig        (sig_q),
      .resp_inv   (bus.resp_inv),
      .resp_nand2 (bus.resp_nand2),
      .next_sig   (next_sig)
   );

   // Run control; data inputs only reach state on valid samples in RUN.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         sig_q  <= SEED;
         cnt_q  <= '0;
         len_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  len_q <= bus.num_cycles;
                  sig_q <= SEED;
                  cnt_q <= '0;
                  if (bus.num_cycles == '0) begin
                     state  <= DONE;
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                  end else begin
                     state  <= RUN;
                     busy_q <= 1'b1;
                     done_q <= 1'b0;
                  end
               end
            end
            RUN: begin
               if (bus.in_valid) begin
                  sig_q <= next_sig;
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (cnt_q == len_q - CNT_W'(1)) begin
                     state  <= DONE;
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                  end
               end
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
               done_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.signature = sig_q;
   assign bus.count     = cnt_q;
   assign bus.pass      = done_q && (sig_q == bus.exp_sig);
endmodule

// File: tb/tb_gate_resp_misr.sv
// Scoreboard bench for gate_resp_misr: random and directed runs against a behavioural MISR model.
module tb_gate_resp_misr;
   localparam int unsigned W  = 64;
   localparam int unsigned CW = 16;
   localparam logic [63:0] P  = 64'hD800_0000_0000_0000;

   logic clk = 1'b0;
   logic rst;
   bit   mon_en = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   gate_resp_misr_if #(.WIDTH(W), .CNT_W(CW)) bus ();

   gate_resp_misr #(.WIDTH(W), .CNT_W(CW), .POLY(P), .SEED(64'h0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [63:0] sig;
      int          cnt;
   } exp_t;

   exp_t        sbq[$];
   logic [63:0] gi[$];
   logic [63:0] gn[$];

   bit          m_run, m_done;
   int          m_len, m_cnt;
   logic [63:0] m_sig;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Signature arithmetic as polynomial shift with feedback plus the folded sample.
   function automatic logic [63:0] fold_ref(input logic [63:0] s, input logic [63:0] a, input logic [63:0] b);
      logic [63:0] rot;
      logic [63:0] fb;
      rot = (b >> 1) | (b << 63);
      fb  = s[63] ? P : 64'h0;
      return (s << 1) ^ fb ^ a ^ rot;
   endfunction

   function automatic logic [63:0] ref_sig();
      logic [63:0] s = 64'h0;
      foreach (gi[i]) s = fold_ref(s, gi[i], gn[i]);
      return s;
   endfunction

   // Behavioural model: tracks run status and pushes the final result on completion.
   always @(posedge clk) begin
      if (rst) begin
         m_run = 0; m_done = 0; m_cnt = 0; m_len = 0; m_sig = 64'h0;
      end else if (!m_run && bus.start) begin
         m_len = int'(bus.num_cycles);
         m_sig = 64'h0;
         m_cnt = 0;
         if (m_len == 0) begin
            m_done = 1;
            sbq.push_back('{m_sig, m_cnt});
         end else begin
            m_run  = 1;
            m_done = 0;
         end
      end else if (m_run && bus.in_valid) begin
         m_sig = fold_ref(m_sig, bus.resp_inv, bus.resp_nand2);
         m_cnt++;
         if (m_cnt == m_len) begin
            m_run  = 0;
            m_done = 1;
            sbq.push_back('{m_sig, m_cnt});
         end
      end
   end

   // Monitor: per-cycle status plus scoreboard pop on each completed run.
   always @(negedge clk) begin
      if (mon_en) begin
         check("busy", 64'(bus.busy), 64'(m_run));
         check("done", 64'(bus.done), 64'(m_done));
         check("count", 64'(bus.count), 64'(m_cnt));
         check("signature", bus.signature, m_sig);
         if (!bus.done) check("pass_not_done", 64'(bus.pass), 64'h0);
         if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            check("done_at_completion", 64'(bus.done), 64'h1);
            check("final_sig", bus.signature, e.sig);
            check("final_count", 64'(bus.count), 64'(e.cnt));
            check("pass", 64'(bus.pass), 64'(bus.exp_sig == e.sig));
         end
      end
   end

   task automatic step(input bit st, input int n, input bit v, input logic [63:0] a, input logic [63:0] b);
      @(posedge clk);
      #1;
      bus.start      = st;
      bus.num_cycles = CW'(n);
      bus.in_valid   = v;
      bus.resp_inv   = v ? a : {$urandom, $urandom};
      bus.resp_nand2 = v ? b : {$urandom, $urandom};
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) step(0, 0, 0, 64'h0, 64'h0);
   endtask

   // Runs the samples in gi/gn with optional random gaps and ignored starts; returns the model signature.
   task automatic run(input bit match, input bit gaps, output logic [63:0] s);
      int n;
      n = gi.size();
      s = ref_sig();
      bus.exp_sig = match ? s : s ^ 64'h1;
      step(1, n, 0, 64'h0, 64'h0);
      for (int i = 0; i < n; i++) begin
         while (gaps && ($urandom_range(0, 2) == 0))
            step($urandom_range(0, 3) == 0, int'($urandom_range(0, 5)), 0, 64'h0, 64'h0);
         step(0, 0, 1, gi[i], gn[i]);
      end
      step(0, 0, 0, 64'h0, 64'h0);
   endtask

   task automatic load1(input logic [63:0] a, input logic [63:0] b);
      gi.delete(); gn.delete();
      gi.push_back(a); gn.push_back(b);
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   logic [63:0] s;

   initial begin
      bus.start = 0; bus.num_cycles = '0; bus.in_valid = 0;
      bus.resp_inv = '0; bus.resp_nand2 = '0; bus.exp_sig = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      mon_en = 1'b1;

      // Reset state held through idle cycles.
      idle(3);
      settle();
      check("reset_sig", bus.signature, 64'h0);
      check("reset_count", 64'(bus.count), 64'h0);
      check("reset_busy", 64'(bus.busy), 64'h0);
      check("reset_done", 64'(bus.done), 64'h0);
      check("reset_pass", 64'(bus.pass), 64'h0);

      // Single sample, matching and mismatching expected signature.
      load1(64'h1, 64'h0);
      run(1, 0, s);
      settle();
      check("t2_sig", bus.signature, 64'h1);
      check("t2_done", 64'(bus.done), 64'h1);
      check("t2_pass", 64'(bus.pass), 64'h1);
      idle(1);
      load1(64'h1, 64'h0);
      run(0, 0, s);
      settle();
      check("t2_fail_pass", 64'(bus.pass), 64'h0);

      // Feedback taps applied when the MSB shifts out.
      gi.delete(); gn.delete();
      gi.push_back(64'h8000_0000_0000_0000); gn.push_back(64'h0);
      gi.push_back(64'h0);                   gn.push_back(64'h0);
      run(1, 0, s);
      settle();
      check("t3_sig", bus.signature, 64'hD800_0000_0000_0000);

      // Rotation of the NAND2 vector and full cancellation.
      load1(64'h0, 64'h1);
      run(1, 0, s);
      settle();
      check("t4_rot_sig", bus.signature, 64'h8000_0000_0000_0000);
      load1(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
      run(1, 0, s);
      settle();
      check("t4_ones_sig", bus.signature, 64'h0);

      // Valid pattern 1,0,0,1,0,1 with an ignored start in RUN, then a zero-length run.
      bus.exp_sig = 64'h0;
      step(1, 3, 0, 64'h0, 64'h0);
      step(0, 0, 1, {$urandom, $urandom}, {$urandom, $urandom});
      step(1, 7, 0, 64'h0, 64'h0);
      step(0, 0, 0, 64'h0, 64'h0);
      step(0, 0, 1, {$urandom, $urandom}, {$urandom, $urandom});
      step(0, 0, 0, 64'h0, 64'h0);
      settle();
      check("t5_count_mid", 64'(bus.count), 64'h2);
      check("t5_busy_mid", 64'(bus.busy), 64'h1);
      step(0, 0, 1, {$urandom, $urandom}, {$urandom, $urandom});
      step(0, 0, 0, 64'h0, 64'h0);
      settle();
      check("t5_done", 64'(bus.done), 64'h1);
      check("t5_count", 64'(bus.count), 64'h3);
      step(1, 0, 0, 64'h0, 64'h0);
      step(0, 0, 0, 64'h0, 64'h0);
      settle();
      check("t5_zero_done", 64'(bus.done), 64'h1);
      check("t5_zero_sig", bus.signature, 64'h0);
      check("t5_zero_count", 64'(bus.count), 64'h0);

      // Reset in the middle of a 10-sample run, then a clean run.
      step(1, 10, 0, 64'h0, 64'h0);
      for (int i = 0; i < 5; i++) step(0, 0, 1, {$urandom, $urandom}, {$urandom, $urandom});
      @(posedge clk);
      #1 rst = 1'b1;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      bus.in_valid = 1'b0;
      settle();
      check("t6_busy", 64'(bus.busy), 64'h0);
      check("t6_sig", bus.signature, 64'h0);
      check("t6_count", 64'(bus.count), 64'h0);
      gi.delete(); gn.delete();
      for (int i = 0; i < 10; i++) begin
         gi.push_back({$urandom, $urandom});
         gn.push_back({$urandom, $urandom});
      end
      run(1, 1, s);
      settle();
      check("t6_rerun_sig", bus.signature, s);
      check("t6_rerun_pass", 64'(bus.pass), 64'h1);

      // Randomised runs with gaps, ignored starts and zero lengths.
      for (int r = 0; r < 40; r++) begin
         int n;
         n = int'($urandom_range(0, 24));
         gi.delete(); gn.delete();
         for (int i = 0; i < n; i++) begin
            gi.push_back({$urandom, $urandom});
            gn.push_back(($urandom_range(0, 3) == 0) ? gi[i] : {$urandom, $urandom});
         end
         run($urandom_range(0, 1) == 1, 1, s);
         idle(int'($urandom_range(0, 2)));
      end

      idle(2);
      settle();
      check("scoreboard_drained", 64'(sbq.size()), 64'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
